// File: rtl/dmem_arbiter.sv
// Two-master data-memory arbiter: core (M0) and loader (M1) share one RAM port.
// Define DMEM_ARB_ROUND_ROBIN_EN for round-robin on contention; default is M0 priority.
module dmem_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              M0_REQ,
    input  logic              M0_WE,
    input  logic [31:0]       M0_ADDR,
    input  logic [DATA_W-1:0] M0_WDATA,
    input  logic              M1_REQ,
    input  logic              M1_WE,
    input  logic [31:0]       M1_ADDR,
    input  logic [DATA_W-1:0] M1_WDATA,
    output logic              M0_GNT,
    output logic              M1_GNT,
    output logic              M0_RVALID,
    output logic              M1_RVALID,
    output logic [DATA_W-1:0] M0_RDATA,
    output logic [DATA_W-1:0] M1_RDATA,
    output logic              RAM_READ,
    output logic              RAM_WRITE,
    output logic [ADDR_W-1:0] RAM_ADDRESS,
    output logic [DATA_W-1:0] RAM_DATAIN,
    input  logic [DATA_W-1:0] RAM_DATAOUT
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic              owner_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;

    logic              any_req;
    logic              win;
    logic              sel_we;
    logic [31:0]       sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              addr_unused;

    assign any_req = M0_REQ | M1_REQ;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    // last_q = 1 means M1 was served last, so M0 wins the next tie
    logic last_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            last_q <= 1'b1;
        end else if (state_q == ACCESS) begin
            last_q <= owner_q;
        end
    end

    always_comb begin
        win = 1'b0;
        if (M0_REQ && M1_REQ) begin
            win = ~last_q;
        end else begin
            win = ~M0_REQ;
        end
    end
`else
    always_comb begin
        win = ~M0_REQ;
    end
`endif

    always_comb begin
        sel_we    = M0_WE;
        sel_addr  = M0_ADDR;
        sel_wdata = M0_WDATA;
        if (win) begin
            sel_we    = M1_WE;
            sel_addr  = M1_ADDR;
            sel_wdata = M1_WDATA;
        end
    end

    // Byte offset and bits above the RAM range are dropped silently
    assign addr_unused = ^{sel_addr[31:ADDR_W+2], sel_addr[1:0]};

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (any_req) state_d = ACCESS;
            ACCESS:  state_d = we_q ? IDLE : RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (state_q == IDLE && any_req) begin
            owner_q <= win;
            we_q    <= sel_we;
            addr_q  <= sel_addr[ADDR_W+1:2];
            wdata_q <= sel_wdata;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else if (state_q == RESP) begin
            if (owner_q) begin
                rdata1_q <= RAM_DATAOUT;
            end else begin
                rdata0_q <= RAM_DATAOUT;
            end
        end
    end

    // RAM data is presented straight through in RESP, then held by the capture regs
    always_comb begin
        M0_GNT      = (state_q == ACCESS) && !owner_q;
        M1_GNT      = (state_q == ACCESS) &&  owner_q;
        M0_RVALID   = (state_q == RESP)   && !owner_q;
        M1_RVALID   = (state_q == RESP)   &&  owner_q;
        M0_RDATA    = M0_RVALID ? RAM_DATAOUT : rdata0_q;
        M1_RDATA    = M1_RVALID ? RAM_DATAOUT : rdata1_q;
        RAM_READ    = (state_q == ACCESS) && !we_q;
        RAM_WRITE   = (state_q == ACCESS) &&  we_q;
        RAM_ADDRESS = addr_q;
        RAM_DATAIN  = wdata_q;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural synchronous RAM.
// Arbitration expectations follow DMEM_ARB_ROUND_ROBIN_EN when defined.
module tb_dmem_arbiter;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    logic              CLK = 1'b0;
    logic              RESET_N;
    logic              M0_REQ, M0_WE, M1_REQ, M1_WE;
    logic [31:0]       M0_ADDR, M1_ADDR;
    logic [DATA_W-1:0] M0_WDATA, M1_WDATA;
    logic              M0_GNT, M1_GNT, M0_RVALID, M1_RVALID;
    logic [DATA_W-1:0] M0_RDATA, M1_RDATA;
    logic              RAM_READ, RAM_WRITE;
    logic [ADDR_W-1:0] RAM_ADDRESS;
    logic [DATA_W-1:0] RAM_DATAIN;
    logic [DATA_W-1:0] RAM_DATAOUT = '0;

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .M0_REQ(M0_REQ), .M0_WE(M0_WE), .M0_ADDR(M0_ADDR), .M0_WDATA(M0_WDATA),
        .M1_REQ(M1_REQ), .M1_WE(M1_WE), .M1_ADDR(M1_ADDR), .M1_WDATA(M1_WDATA),
        .M0_GNT(M0_GNT), .M1_GNT(M1_GNT),
        .M0_RVALID(M0_RVALID), .M1_RVALID(M1_RVALID),
        .M0_RDATA(M0_RDATA), .M1_RDATA(M1_RDATA),
        .RAM_READ(RAM_READ), .RAM_WRITE(RAM_WRITE),
        .RAM_ADDRESS(RAM_ADDRESS), .RAM_DATAIN(RAM_DATAIN),
        .RAM_DATAOUT(RAM_DATAOUT)
    );

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
    end

    always @(posedge CLK) begin
        if (RAM_WRITE) mem[RAM_ADDRESS] <= RAM_DATAIN;
        if (RAM_READ) RAM_DATAOUT <= mem[RAM_ADDRESS];
    end

    typedef struct packed {
        logic        m0_req;
        logic        m0_we;
        logic [31:0] m0_addr;
        logic [31:0] m0_wdata;
        logic        m1_req;
        logic        m1_we;
        logic [31:0] m1_addr;
        logic [31:0] m1_wdata;
    } in_t;

    typedef struct packed {
        logic        m0_gnt;
        logic        m0_rvalid;
        logic [31:0] m0_rdata;
        logic        m1_gnt;
        logic        m1_rvalid;
        logic [31:0] m1_rdata;
        logic        ram_read;
        logic        ram_write;
        logic [9:0]  ram_address;
        logic [31:0] ram_datain;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    function automatic in_t mk_in(logic r0, logic w0, logic [31:0] a0, logic [31:0] d0,
                                  logic r1, logic w1, logic [31:0] a1, logic [31:0] d1);
        in_t v;
        v = '{r0, w0, a0, d0, r1, w1, a1, d1};
        return v;
    endfunction

    function automatic out_t mk_out(logic g0, logic v0, logic [31:0] d0,
                                    logic g1, logic v1, logic [31:0] d1,
                                    logic rd, logic wr, logic [9:0] ad, logic [31:0] di);
        out_t v;
        v = '{g0, v0, d0, g1, v1, d1, rd, wr, ad, di};
        return v;
    endfunction

    function automatic out_t grab();
        out_t v;
        v = '{M0_GNT, M0_RVALID, M0_RDATA, M1_GNT, M1_RVALID, M1_RDATA,
              RAM_READ, RAM_WRITE, RAM_ADDRESS, RAM_DATAIN};
        return v;
    endfunction

    task automatic drive(input in_t v);
        M0_REQ   = v.m0_req;
        M0_WE    = v.m0_we;
        M0_ADDR  = v.m0_addr;
        M0_WDATA = v.m0_wdata;
        M1_REQ   = v.m1_req;
        M1_WE    = v.m1_we;
        M1_ADDR  = v.m1_addr;
        M1_WDATA = v.m1_wdata;
    endtask

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    vec_t vecs [13];
    in_t  idle_in;
    in_t  m1_wr;
    out_t z_out;

    initial begin
        int gnt_seen;
        int cyc;
        logic exp_owner;

        idle_in = mk_in(0, 0, 0, 0, 0, 0, 0, 0);
        z_out   = mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        m1_wr   = mk_in(0, 0, 0, 0, 1, 1, 32'h20, 32'hCAFE_0001);

        vecs[0]  = '{idle_in, z_out};
        vecs[1]  = '{mk_in(1, 1, 32'h10, 32'hDEAD_BEEF, 0, 0, 0, 0), z_out};
        vecs[2]  = '{idle_in,
                     mk_out(1, 0, 0, 0, 0, 0, 0, 1, 10'd4, 32'hDEAD_BEEF)};
        vecs[3]  = '{mk_in(0, 0, 0, 0, 1, 0, 32'h10, 32'h1111_2222),
                     mk_out(0, 0, 0, 0, 0, 0, 0, 0, 10'd4, 32'hDEAD_BEEF)};
        vecs[4]  = '{idle_in,
                     mk_out(0, 0, 0, 1, 0, 0, 1, 0, 10'd4, 32'h1111_2222)};
        vecs[5]  = '{idle_in,
                     mk_out(0, 0, 0, 0, 1, 32'hDEAD_BEEF, 0, 0, 10'd4, 32'h1111_2222)};
        vecs[6]  = '{idle_in,
                     mk_out(0, 0, 0, 0, 0, 32'hDEAD_BEEF, 0, 0, 10'd4, 32'h1111_2222)};
        vecs[7]  = '{mk_in(1, 0, 32'hFFFF_F013, 0, 0, 0, 0, 0),
                     mk_out(0, 0, 0, 0, 0, 32'hDEAD_BEEF, 0, 0, 10'd4, 32'h1111_2222)};
        vecs[8]  = '{m1_wr,
                     mk_out(1, 0, 0, 0, 0, 32'hDEAD_BEEF, 1, 0, 10'd4, 0)};
        vecs[9]  = '{m1_wr,
                     mk_out(0, 1, 32'hDEAD_BEEF, 0, 0, 32'hDEAD_BEEF, 0, 0, 10'd4, 0)};
        vecs[10] = '{m1_wr,
                     mk_out(0, 0, 32'hDEAD_BEEF, 0, 0, 32'hDEAD_BEEF, 0, 0, 10'd4, 0)};
        vecs[11] = '{idle_in,
                     mk_out(0, 0, 32'hDEAD_BEEF, 1, 0, 32'hDEAD_BEEF, 0, 1, 10'd8, 32'hCAFE_0001)};
        vecs[12] = '{idle_in,
                     mk_out(0, 0, 32'hDEAD_BEEF, 0, 0, 32'hDEAD_BEEF, 0, 0, 10'd8, 32'hCAFE_0001)};

        RESET_N = 1'b0;
        drive(idle_in);
        #12;
        check("reset_outputs", 128'(grab()), 128'(z_out));
        @(negedge CLK);
        RESET_N = 1'b1;

        for (int k = 0; k < 13; k++) begin
            @(negedge CLK);
            drive(vecs[k].i);
            #1;
            check($sformatf("vec%0d", k), 128'(grab()), 128'(vecs[k].o));
            if (RAM_READ && RAM_WRITE) begin
                check("strobe_overlap", 128'({RAM_READ, RAM_WRITE}), 128'(0));
            end
        end

        // Both masters hold read requests continuously
        @(negedge CLK);
        drive(mk_in(1, 0, 32'h10, 0, 1, 0, 32'h20, 0));
        gnt_seen = 0;
        cyc = 0;
        while (gnt_seen < 4 && cyc < 40) begin
            @(negedge CLK);
            #1;
            cyc++;
            if (M0_GNT || M1_GNT) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                exp_owner = gnt_seen[0];
`else
                exp_owner = 1'b0;
`endif
                check($sformatf("contend_gnt%0d", gnt_seen),
                      128'({M0_GNT, M1_GNT}), 128'({~exp_owner, exp_owner}));
                gnt_seen++;
            end
            if (M0_RVALID) check("contend_m0_rdata", 128'(M0_RDATA), 128'(32'hDEAD_BEEF));
            if (M1_RVALID) check("contend_m1_rdata", 128'(M1_RDATA), 128'(32'hCAFE_0001));
        end
        check("contend_timeout", 128'(gnt_seen), 128'(4));
        drive(idle_in);
        repeat (3) @(negedge CLK);

        // Reset asserted while an M0 read is in its response cycle
        drive(mk_in(1, 0, 32'h10, 0, 0, 0, 0, 0));
        @(negedge CLK);
        drive(idle_in);
        @(negedge CLK);
        #1;
        check("pre_reset_rvalid", 128'({M0_RVALID, M0_RDATA}), 128'({1'b1, 32'hDEAD_BEEF}));
        RESET_N = 1'b0;
        #1;
        check("mid_resp_reset", 128'(grab()), 128'(z_out));
        @(negedge CLK);
        RESET_N = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            #1;
            check($sformatf("post_reset%0d", k), 128'(grab()), 128'(z_out));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
